// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl
//   Per-domain automatic clock-gating controller. Each domain runs a small
//   RUN / GATED / WAKE state machine. After IDLE_CYCLES consecutive idle
//   cycles the domain clock enable drops. A wake request, or a drop of the
//   global enable, restores the clock. The domain then waits WAKE_CYCLES
//   settle cycles before it reports ready again.
//
//   Optional build macro CLOCK_GATE_CTRL_STATS_EN adds one saturating 32-bit
//   gated-cycle counter per domain, plus the cnt_clr_i / gated_cycles_o ports.
//   Without the macro those ports and counters do not exist.
//
//   Reset is synchronous and active-high (rst_i).

module clock_gate_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [NUM_DOMAINS-1:0] idle_i,
    input  logic [NUM_DOMAINS-1:0] wake_req_i,
    output logic [NUM_DOMAINS-1:0] clk_en_o,
    output logic [NUM_DOMAINS-1:0] ready_o,
    output logic [NUM_DOMAINS-1:0] gated_o
`ifdef CLOCK_GATE_CTRL_STATS_EN
    ,
    input  logic                      cnt_clr_i,
    output logic [32*NUM_DOMAINS-1:0] gated_cycles_o
`endif
);

    // ------------------------------------------------------------------
    // Parameter legality, rejected at elaboration
    // ------------------------------------------------------------------
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 16) begin : g_bad_num_domains
        $error("clock_gate_ctrl: NUM_DOMAINS must be in 1..16");
    end
    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 1024) begin : g_bad_idle_cycles
        $error("clock_gate_ctrl: IDLE_CYCLES must be in 1..1024");
    end
    if (WAKE_CYCLES < 1 || WAKE_CYCLES > 64) begin : g_bad_wake_cycles
        $error("clock_gate_ctrl: WAKE_CYCLES must be in 1..64");
    end

    // ------------------------------------------------------------------
    // Shared counter sizing
    // ------------------------------------------------------------------
    // One counter per domain serves as the idle counter in RUN and as the
    // settle counter in WAKE. It must hold the larger of the two terminal
    // values.
    localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    // The state bits are the outputs themselves: {clk_en, ready, gated}.
    // Every output therefore comes straight from a flop, with no decode
    // logic between the state register and the clock-gate cell.
    typedef enum logic [2:0] {
        ST_RUN   = 3'b110,
        ST_GATED = 3'b001,
        ST_WAKE  = 3'b100
    } state_e;

    // ------------------------------------------------------------------
    // Per-domain controllers
    // ------------------------------------------------------------------
    for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom

        state_e           state;
        state_e           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             idle_qual;

        // A cycle counts toward gating only when auto-gating is enabled,
        // the domain is idle and nobody wants it awake. A wake request
        // beats a simultaneous idle indication.
        assign idle_qual = enable_i & idle_i[d] & ~wake_req_i[d];

        // State and counter registers; reset returns straight to RUN.
        always_ff @(posedge clk_i) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the pre-edge values no matter how the blocks are
            // ordered.
            if (rst_i) begin
                state <= ST_RUN;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end

        // Next-state and counter logic for one domain.
        always_comb begin
            // NOTE: every combinational output gets a default first, so no
            // path through the case leaves a value unassigned (no latch).
            state_nxt = state;
            cnt_nxt   = '0;

            unique case (state)
                ST_RUN: begin
                    if (idle_qual) begin
                        if (cnt == IDLE_LAST) begin
                            state_nxt = ST_GATED;
                        end else begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                    end
                end

                ST_GATED: begin
                    if (wake_req_i[d] || !enable_i) begin
                        state_nxt = ST_WAKE;
                    end
                end

                ST_WAKE: begin
                    // Idle and wake inputs are deliberately ignored here;
                    // the settle period always runs to completion.
                    if (cnt == WAKE_LAST) begin
                        state_nxt = ST_RUN;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end

                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end

        assign clk_en_o[d] = state[2];
        assign ready_o[d]  = state[1];
        assign gated_o[d]  = state[0];
    end

    // ------------------------------------------------------------------
    // Optional gated-cycle statistics
    // ------------------------------------------------------------------
`ifdef CLOCK_GATE_CTRL_STATS_EN

    logic [31:0] stat_cnt [NUM_DOMAINS];

    // Count cycles spent GATED per domain. The count saturates at all-ones,
    // and clear has priority over increment.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (rst_i || cnt_clr_i) begin
                stat_cnt[i] <= '0;
            end else if (gated_o[i] && (stat_cnt[i] != 32'hFFFF_FFFF)) begin
                stat_cnt[i] <= stat_cnt[i] + 32'd1;
            end
        end
    end

    // Flatten the counter array onto the output bus; domain 0 is in the
    // least significant bits.
    always_comb begin
        gated_cycles_o = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            gated_cycles_o[32*i +: 32] = stat_cnt[i];
        end
    end

`else

    // Statistics are not built: no counters and no extra ports.

`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb_clock_gate_ctrl
//   Directed testbench for clock_gate_ctrl with its default parameters
//   (4 domains, IDLE_CYCLES=16, WAKE_CYCLES=2). Every expected value below
//   is worked out by hand from the cycle-level behaviour.
//
//   Inputs change 1 ns after a rising edge. Outputs are sampled at that same
//   point, so each check sees the state loaded by the edge just passed.

module tb_clock_gate_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic       enable_i;
    logic [3:0] idle_i;
    logic [3:0] wake_req_i;
    logic [3:0] clk_en_o;
    logic [3:0] ready_o;
    logic [3:0] gated_o;
`ifdef CLOCK_GATE_CTRL_STATS_EN
    logic         cnt_clr_i;
    logic [127:0] gated_cycles_o;
`endif

    int checks;
    int errors;

    clock_gate_ctrl #(
        .NUM_DOMAINS (4),
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .idle_i     (idle_i),
        .wake_req_i (wake_req_i),
        .clk_en_o   (clk_en_o),
        .ready_o    (ready_o),
        .gated_o    (gated_o)
`ifdef CLOCK_GATE_CTRL_STATS_EN
        ,
        .cnt_clr_i      (cnt_clr_i),
        .gated_cycles_o (gated_cycles_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_dut();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] en,
                              input logic [3:0] rdy, input logic [3:0] gtd);
        check({tag, "_clk_en"}, 32'(clk_en_o), 32'(en));
        check({tag, "_ready"},  32'(ready_o),  32'(rdy));
        check({tag, "_gated"},  32'(gated_o),  32'(gtd));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_i      = 1'b0;
        enable_i   = 1'b1;
        idle_i     = 4'b0000;
        wake_req_i = 4'b0000;
`ifdef CLOCK_GATE_CTRL_STATS_EN
        cnt_clr_i  = 1'b0;
`endif

        // Reset state: every domain running and ready.
        reset_dut();
        check_outs("reset", 4'hF, 4'hF, 4'h0);

        // Domain 0 idle from cycle 0. Still running after 15 samples; gated
        // once the 16th sample lands. Other domains stay untouched.
        idle_i = 4'b0001;
        steps(15);
        check_outs("idle15", 4'hF, 4'hF, 4'h0);
        step();
        check_outs("idle16", 4'hE, 4'hE, 4'h1);

        // GATED holds once idle drops, as long as no wake request arrives.
        idle_i = 4'b0000;
        steps(3);
        check_outs("gated_hold", 4'hE, 4'hE, 4'h1);

        // Wake pulse on domain 0. The clock returns next cycle; ready only
        // after two settle cycles.
        wake_req_i = 4'b0001;
        step();
        wake_req_i = 4'b0000;
        check_outs("wake0_t1", 4'hF, 4'hE, 4'h0);
        step();
        check("wake0_t2_ready", 32'(ready_o), 32'h0000_000E);
        step();
        check("wake0_t3_ready", 32'(ready_o), 32'h0000_000F);

        // The idle run restarts after an interruption. Domain 1 sees a plain
        // non-idle cycle; domain 3 sees idle and wake together, which also
        // counts as non-idle. Neither gates after 15+1+15 cycles, and both
        // gate together on the following idle sample.
        reset_dut();
        idle_i = 4'b1010;
        steps(15);
        idle_i     = 4'b1000;
        wake_req_i = 4'b1000;
        step();
        idle_i     = 4'b1010;
        wake_req_i = 4'b0000;
        steps(15);
        check_outs("restart15", 4'hF, 4'hF, 4'h0);
        step();
        check_outs("restart16", 4'h5, 4'h5, 4'hA);

        // Domain 2 gated, then woken by a single-cycle wake pulse.
        reset_dut();
        idle_i = 4'b0100;
        steps(16);
        check("d2_gated", 32'(gated_o), 32'h0000_0004);
        idle_i = 4'b0000;
        steps(2);
        wake_req_i = 4'b0100;
        step();
        wake_req_i = 4'b0000;
        check_outs("d2_t1", 4'hF, 4'hB, 4'h0);
        step();
        check("d2_t2_ready", 32'(ready_o), 32'h0000_000B);
        step();
        check("d2_t3_ready", 32'(ready_o), 32'h0000_000F);

        // All domains gated. Dropping enable wakes them all together, and
        // nothing regates while enable stays low, even with idle held high.
        reset_dut();
        idle_i = 4'hF;
        steps(16);
        check_outs("all_gated", 4'h0, 4'h0, 4'hF);
        enable_i = 1'b0;
        step();
        check_outs("en_drop_t1", 4'hF, 4'h0, 4'h0);
        step();
        check("en_drop_t2_ready", 32'(ready_o), 32'h0000_0000);
        step();
        check("en_drop_t3_ready", 32'(ready_o), 32'h0000_000F);
        steps(20);
        check_outs("en_low_hold", 4'hF, 4'hF, 4'h0);

        // With enable back high, idle counting starts from zero.
        enable_i = 1'b1;
        steps(15);
        check("reen15_gated", 32'(gated_o), 32'h0000_0000);
        step();
        check("reen16_gated", 32'(gated_o), 32'h0000_000F);

        // Domains 0/1 in WAKE, domains 2/3 GATED. Reset wins over a
        // concurrent wake request and returns everything straight to RUN.
        wake_req_i = 4'b0011;
        step();
        wake_req_i = 4'b0000;
        check_outs("mixed", 4'h3, 4'h0, 4'hC);
        rst_i      = 1'b1;
        wake_req_i = 4'b0100;
        step();
        rst_i      = 1'b0;
        wake_req_i = 4'b0000;
        idle_i     = 4'b0000;
        check_outs("rst_mid", 4'hF, 4'hF, 4'h0);

`ifdef CLOCK_GATE_CTRL_STATS_EN
        // Gated-cycle counter: it counts each cycle spent GATED, clear has
        // priority, and the count saturates at all-ones.
        reset_dut();
        check("stat_reset", gated_cycles_o[31:0], 32'd0);
        idle_i = 4'b0001;
        steps(16);
        check("stat_enter", gated_cycles_o[31:0], 32'd0);
        steps(10);
        check("stat_10", gated_cycles_o[31:0], 32'd10);
        check("stat_d1", gated_cycles_o[63:32], 32'd0);
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        check("stat_clr", gated_cycles_o[31:0], 32'd0);
        dut.stat_cnt[0] = 32'hFFFF_FFFE;
        step();
        check("stat_max", gated_cycles_o[31:0], 32'hFFFF_FFFF);
        step();
        check("stat_sat", gated_cycles_o[31:0], 32'hFFFF_FFFF);
        idle_i = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_gate_ctrl.md
CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 4, number of independently gated clock domains (1..16).
REQ-002 Parameter IDLE_CYCLES, default 16, consecutive idle cycles before gating (legal range 1..1024).
REQ-003 Parameter WAKE_CYCLES, default 2, settle cycles after ungating before ready (legal range 1..64).
REQ-004 clk_i  input  1  free-running clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 enable_i  input  1  global auto-gating enable; 0 forces all domains toward running.
REQ-007 idle_i  input  NUM_DOMAINS  per-domain idle indication from the domain logic.
REQ-008 wake_req_i  input  NUM_DOMAINS  per-domain wake request (level).
REQ-009 clk_en_o  output  NUM_DOMAINS  registered enable for the per-domain cv32e40p_clock_gate en_i.
REQ-010 ready_o  output  NUM_DOMAINS  domain clocked and settled; requesters may issue work.
REQ-011 gated_o  output  NUM_DOMAINS  domain currently gated.

Function
REQ-012 Each domain SHALL have an independent FSM with states RUN, GATED, WAKE and an idle/settle counter sized for max(IDLE_CYCLES, WAKE_CYCLES).
REQ-013 Outputs per state SHALL be: RUN clk_en=1 ready=1 gated=0; GATED clk_en=0 ready=0 gated=1; WAKE clk_en=1 ready=0 gated=0; all driven directly from state registers.
REQ-014 RUN: counter SHALL increment each cycle with enable_i=1, idle_i=1, wake_req_i=0; any other cycle SHALL clear it to 0.
REQ-015 RUN->GATED SHALL occur on the edge that samples the IDLE_CYCLES-th consecutive qualifying cycle; idle sampled in cycles 0..15 (default) gives clk_en_o=0 from cycle 16.
REQ-016 GATED->WAKE SHALL occur on the edge sampling wake_req_i=1 or enable_i=0; counter cleared; clk_en_o=1 in the next cycle.
REQ-017 WAKE SHALL last exactly WAKE_CYCLES cycles, then go to RUN; wake request sampled in cycle t gives ready_o=1 at cycle t+1+WAKE_CYCLES.
REQ-018 In WAKE, idle_i and wake_req_i SHALL be ignored; WAKE always completes.
REQ-019 Simultaneous idle_i=1 and wake_req_i=1 in RUN SHALL count as non-idle (wake wins, counter cleared).
REQ-020 enable_i=0 SHALL prevent any RUN->GATED transition and wake every GATED domain via WAKE.
REQ-021 Domains SHALL not interact; simultaneous transitions on several domains SHALL all take effect in the same cycle.
REQ-022 Out-of-range parameters SHALL cause an elaboration-time error.

Reset
REQ-023 rst_i=1 on a clock edge SHALL place every domain in RUN with counter 0: clk_en_o all 1, ready_o all 1, gated_o all 0 from the next cycle.
REQ-024 Reset asserted while a domain is GATED or WAKE SHALL return it to RUN without passing through WAKE.
REQ-025 Reset SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-026 Macro CLOCK_GATE_CTRL_STATS_EN defined SHALL add ports cnt_clr_i (input, 1) and gated_cycles_o (output, 32*NUM_DOMAINS), one 32-bit counter per domain.
REQ-027 With the macro, each counter SHALL increment on every cycle its domain is GATED, saturate at 0xFFFFFFFF, clear on cnt_clr_i=1 (clear wins over increment) and reset to 0.
REQ-028 Without the macro, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then domain 0 idle 16 cycles, enable_i=1 -> clk_en_o[0]=0, gated_o[0]=1 at cycle 16; other domains unchanged.
REQ-030 Idle 15 cycles, one non-idle cycle, idle 15 -> domain never gates; counter restarts.
REQ-031 Gated domain 2, wake_req_i[2] pulse at cycle t -> clk_en_o[2]=1 at t+1, ready_o[2]=1 at t+3 (WAKE_CYCLES=2).
REQ-032 All domains gated, enable_i dropped -> all enter WAKE together, all ready after 2 cycles; no regating while enable_i=0.
REQ-033 rst_i asserted mid-WAKE and mid-GATED -> next cycle clk_en_o=all 1, ready_o=all 1.
REQ-034 With CLOCK_GATE_CTRL_STATS_EN: domain gated for 10 cycles -> gated_cycles_o[0]=10; cnt_clr_i pulse -> 0; preloaded near-max counter saturates at 0xFFFFFFFF.
